// File: rtl/hier_collect_pkg.sv
// Shared widths, entry layout and width helpers for the hierarchy status collector.
// No logic; no latency or backpressure of its own.
package hier_collect_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int NUM_CHILD_DEF = 5;

  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int IDX_W_DEF = idx_width(NUM_CHILD_DEF);

  typedef struct packed {
    logic [IDX_W_DEF-1:0]  idx;
    logic [DATA_W_DEF-1:0] data;
  } entry_t;

endpackage

// File: rtl/hier_rr_arbiter.sv
// Round-robin grant search starting at pointer, ascending with wrap; purely combinational.
// Zero latency; enable low forces no grant so the requester sees backpressure.
module hier_rr_arbiter
  import hier_collect_pkg::*;
#(
  parameter  int N  = 5,
  localparam int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  input  logic          enable,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  int          cand;
  logic [IW-1:0] cand_idx;
  logic        found;

  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand = int'(pointer) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IW'(cand);
      if (enable && !found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        gnt_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/hier_status_collector.sv
// Fan-in of child status words: round-robin accept, tag with child index, show-ahead FIFO upstream.
// One cycle from accept to up_valid when empty; children stalled while the FIFO is full or in reset.
module hier_status_collector
  import hier_collect_pkg::*;
#(
  parameter  int NUM_CHILD  = NUM_CHILD_DEF,
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int FIFO_DEPTH = 4,
  localparam int IDX_W      = idx_width(NUM_CHILD),
  localparam int CNT_W      = cnt_width(FIFO_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CHILD-1:0]        child_valid,
  input  logic [NUM_CHILD*DATA_W-1:0] child_data,
  output logic [NUM_CHILD-1:0]        child_ready,
  output logic                        up_valid,
  output logic [DATA_W-1:0]           up_data,
  output logic [IDX_W-1:0]            up_idx,
  input  logic                        up_ready,
  output logic [CNT_W-1:0]            count,
  output logic                        busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

  fifo_entry_t       mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;

  logic [DATA_W-1:0] child_word [NUM_CHILD];
  logic [IDX_W-1:0]  gnt_idx;
  logic              full;
  logic              push;
  logic              pop;
  fifo_entry_t       head;

  for (genvar g = 0; g < NUM_CHILD; g++) begin : g_unpack
    assign child_word[g] = child_data[g*DATA_W +: DATA_W];
  end

  assign full = (count_q == CNT_W'(FIFO_DEPTH));

  // Gating with rst keeps child_ready low while reset is held, not just after release.
  hier_rr_arbiter #(.N(NUM_CHILD)) u_arb (
    .req     (child_valid),
    .pointer (rr_ptr_q),
    .enable  (!full && !rst),
    .gnt     (child_ready),
    .gnt_idx (gnt_idx)
  );

  assign push = |(child_valid & child_ready);
  assign pop  = up_valid && up_ready;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rr_ptr_d = rr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      rr_ptr_d = (gnt_idx == IDX_W'(NUM_CHILD - 1)) ? '0 : gnt_idx + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      rr_ptr_q <= rr_ptr_d;
      if (push) mem_q[wr_ptr_q] <= fifo_entry_t'{idx: gnt_idx, data: child_word[gnt_idx]};
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign up_valid = (count_q != '0);
  assign up_data  = head.data;
  assign up_idx   = head.idx;
  assign count    = count_q;
  assign busy     = (count_q != '0) || (|child_valid);

endmodule

// File: tb/tb_hier_status_collector.sv
// Directed bench for hier_status_collector with hand-computed expectations.
module tb_hier_status_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  child_valid;
  logic [39:0] child_data;
  logic [4:0]  child_ready;
  logic        up_valid;
  logic [7:0]  up_data;
  logic [2:0]  up_idx;
  logic        up_ready;
  logic [2:0]  count;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  hier_status_collector dut (
    .clk         (clk),
    .rst         (rst),
    .child_valid (child_valid),
    .child_data  (child_data),
    .child_ready (child_ready),
    .up_valid    (up_valid),
    .up_data     (up_data),
    .up_idx      (up_idx),
    .up_ready    (up_ready),
    .count       (count),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    child_valid = '0;
    up_ready    = 1'b0;
    for (int i = 0; i < 5; i++) child_data[i*8 +: 8] = 8'h10 + 8'(i);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_up_valid", 32'(up_valid), 0);
    chk("rst_up_data", 32'(up_data), 0);
    chk("rst_up_idx", 32'(up_idx), 0);
    chk("rst_child_ready", 32'(child_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;

    // Single child 2 word
    tick();
    child_data[2*8 +: 8] = 8'hA5;
    child_valid = 5'b00100;
    up_ready    = 1'b1;
    #1;
    chk("single_ready", 32'(child_ready), 32'b00100);
    chk("single_busy", 32'(busy), 1);
    tick();
    child_valid = '0;
    #1;
    chk("single_up_valid", 32'(up_valid), 1);
    chk("single_up_idx", 32'(up_idx), 2);
    chk("single_up_data", 32'(up_data), 32'hA5);
    chk("single_count", 32'(count), 1);
    chk("single_ready_off", 32'(child_ready), 0);
    tick();
    chk("single_drained", 32'(count), 0);
    chk("single_up_valid_off", 32'(up_valid), 0);
    chk("idle_busy", 32'(busy), 0);
    child_data[2*8 +: 8] = 8'h12;

    // All children valid, free-flowing upstream
    rst_pulse();
    child_valid = 5'b11111;
    up_ready    = 1'b1;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk($sformatf("rr_ready_%0d", k), 32'(child_ready), 32'(1 << (k % 5)));
      tick();
      chk($sformatf("rr_idx_%0d", k), 32'(up_idx), 32'(k % 5));
      chk($sformatf("rr_data_%0d", k), 32'(up_data), 32'(8'h10 + 8'(k % 5)));
      chk($sformatf("rr_count_%0d", k), 32'(count), 1);
    end
    child_valid = '0;
    tick();
    chk("rr_drained", 32'(count), 0);

    // Fill with upstream stalled
    rst_pulse();
    child_valid = 5'b11111;
    up_ready    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("fill_ready_%0d", k), 32'(child_ready), 32'(1 << k));
      tick();
      chk($sformatf("fill_count_%0d", k), 32'(count), 32'(k + 1));
    end
    chk("full_ready_off", 32'(child_ready), 0);

    // Full with pop and child 4 valid in the same cycle
    child_valid = 5'b10000;
    up_ready    = 1'b1;
    #1;
    chk("full_pop_ready_off", 32'(child_ready), 0);
    chk("drain_idx_0", 32'(up_idx), 0);
    chk("drain_data_0", 32'(up_data), 32'h10);
    tick();
    chk("full_pop_count", 32'(count), 3);
    up_ready = 1'b0;
    #1;
    chk("refill_ready", 32'(child_ready), 32'b10000);
    tick();
    chk("refill_count", 32'(count), 4);
    child_valid = '0;
    up_ready    = 1'b1;
    for (int k = 1; k < 5; k++) begin
      #1;
      chk($sformatf("drain_idx_%0d", k), 32'(up_idx), 32'(k));
      chk($sformatf("drain_data_%0d", k), 32'(up_data), 32'(8'h10 + 8'(k)));
      tick();
      chk($sformatf("drain_count_%0d", k), 32'(count), 32'(4 - k));
    end

    // Pointer wrap after grant to child 4
    child_valid = 5'b01010;
    #1;
    chk("wrap_grant_1", 32'(child_ready), 32'b00010);
    tick();
    chk("wrap_head_1", 32'(up_idx), 1);
    chk("wrap_grant_3", 32'(child_ready), 32'b01000);
    tick();
    chk("wrap_head_3", 32'(up_idx), 3);
    chk("wrap_count", 32'(count), 1);
    chk("wrap_grant_1b", 32'(child_ready), 32'b00010);
    child_valid = '0;
    tick();
    chk("wrap_drained", 32'(count), 0);

    // Async reset mid-stream with three entries buffered
    child_valid = 5'b11111;
    up_ready    = 1'b0;
    tick();
    tick();
    tick();
    chk("pre_rst_count", 32'(count), 3);
    chk("pre_rst_head", 32'(up_idx), 4);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_up_valid", 32'(up_valid), 0);
    chk("async_rst_ready", 32'(child_ready), 0);
    rst = 1'b0;
    #1;
    chk("post_rst_grant", 32'(child_ready), 32'b00001);
    tick();
    chk("post_rst_idx", 32'(up_idx), 0);
    chk("post_rst_count", 32'(count), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
